// File: rtl/scan_mux_pkg.sv
// Shared types and helpers for the scan_mux channel selector.
package scan_mux_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StManual,
    StScan
  } state_e;

  // Width needed to index n items; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_mux_sel.sv
// Combinational N:1 W-bit channel selector; out-of-range indices yield zero data and err.
module scan_mux_sel
  import scan_mux_pkg::*;
#(
  parameter int unsigned N  = 7,
  parameter int unsigned W  = 1,
  parameter int unsigned SW = sel_width(N)
) (
  input  logic [N*W-1:0] a,
  input  logic [SW-1:0]  idx,
  output logic [W-1:0]   data,
  output logic           err
);

  always_comb begin
    data = '0;
    err  = 1'b1;
    for (int k = 0; k < int'(N); k++) begin
      if (idx == SW'(k)) begin
        data = a[k*W +: W];
        err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/scan_mux.sv
// Registered channel multiplexer with manual single-shot selection and dwell-timed auto-scan.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int unsigned N     = 7,
  parameter int unsigned W     = 1,
  parameter int unsigned DWELL = 1,
  localparam int unsigned SW   = sel_width(N),
  localparam int unsigned DW   = sel_width(DWELL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N*W-1:0] a,
  input  logic [SW-1:0] s,
  input  logic          s_valid,
  input  logic          scan_en,
  output logic [W-1:0]  out,
  output logic          out_valid,
  output logic [SW-1:0] cur_ch,
  output logic          sel_err,
  output logic          wrap
);

  state_e        state_q, state_d;
  logic [SW-1:0] req_q;
  logic [SW-1:0] ch_q;
  logic [DW-1:0] dwell_q;
  logic          wrap_pend_q;

  logic [SW-1:0] sel_idx;
  logic [W-1:0]  sel_data;
  logic          sel_oor;

  assign sel_idx = (state_q == StScan) ? ch_q : req_q;

  scan_mux_sel #(
    .N  (N),
    .W  (W),
    .SW (SW)
  ) u_sel (
    .a    (a),
    .idx  (sel_idx),
    .data (sel_data),
    .err  (sel_oor)
  );

  // scan_en has priority over a manual request in every state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (scan_en)      state_d = StScan;
        else if (s_valid) state_d = StManual;
      end
      StManual: begin
        if (scan_en)      state_d = StScan;
        else if (s_valid) state_d = StManual;
        else              state_d = StIdle;
      end
      StScan: begin
        if (!scan_en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      req_q       <= '0;
      ch_q        <= '0;
      dwell_q     <= '0;
      wrap_pend_q <= 1'b0;
      out         <= '0;
      out_valid   <= 1'b0;
      cur_ch      <= '0;
      sel_err     <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!scan_en && s_valid) req_q <= s;
        end
        StManual: begin
          out       <= sel_data;
          cur_ch    <= req_q;
          out_valid <= 1'b1;
          sel_err   <= sel_oor;
          if (!scan_en && s_valid) req_q <= s;
        end
        StScan: begin
          if (scan_en) begin
            out         <= sel_data;
            cur_ch      <= ch_q;
            out_valid   <= 1'b1;
            wrap        <= wrap_pend_q;
            wrap_pend_q <= 1'b0;
            if (dwell_q == DW'(DWELL - 1)) begin
              dwell_q <= '0;
              if (ch_q == SW'(N - 1)) begin
                ch_q        <= '0;
                wrap_pend_q <= 1'b1;
              end else begin
                ch_q <= ch_q + SW'(1);
              end
            end else begin
              dwell_q <= dwell_q + DW'(1);
            end
          end
        end
        default: ;
      endcase
      // Every fresh entry into scan starts from channel 0.
      if (state_d == StScan && state_q != StScan) begin
        ch_q        <= '0;
        dwell_q     <= '0;
        wrap_pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// Directed self-checking bench for scan_mux (N=7, W=1, DWELL=2).
module tb_scan_mux;

  localparam int unsigned N     = 7;
  localparam int unsigned W     = 1;
  localparam int unsigned DWELL = 2;
  localparam int unsigned SW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*W-1:0] a;
  logic [SW-1:0] s;
  logic          s_valid;
  logic          scan_en;
  logic [W-1:0]  out;
  logic          out_valid;
  logic [SW-1:0] cur_ch;
  logic          sel_err;
  logic          wrap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_mux #(
    .N     (N),
    .W     (W),
    .DWELL (DWELL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .s         (s),
    .s_valid   (s_valid),
    .scan_en   (scan_en),
    .out       (out),
    .out_valid (out_valid),
    .cur_ch    (cur_ch),
    .sel_err   (sel_err),
    .wrap      (wrap)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    chk("reset_out", 32'(out), 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_cur_ch", 32'(cur_ch), 0);
    chk("reset_sel_err", 32'(sel_err), 0);
    chk("reset_wrap", 32'(wrap), 0);
    rst = 1'b0;
    step();
  endtask

  task automatic test_manual();
    s = 3'd2; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    chk("manual_latency_valid", 32'(out_valid), 0);
    step();
    chk("manual_out", 32'(out), 1);
    chk("manual_cur_ch", 32'(cur_ch), 2);
    chk("manual_valid", 32'(out_valid), 1);
    chk("manual_sel_err", 32'(sel_err), 0);
    step();
    chk("manual_valid_drop", 32'(out_valid), 0);
  endtask

  task automatic test_out_of_range();
    s = 3'd7; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    step();
    chk("oor_out", 32'(out), 0);
    chk("oor_cur_ch", 32'(cur_ch), 7);
    chk("oor_valid", 32'(out_valid), 1);
    chk("oor_sel_err", 32'(sel_err), 1);
    step();
    chk("oor_sel_err_hold", 32'(sel_err), 1);
    chk("oor_valid_drop", 32'(out_valid), 0);
    s = 3'd0; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    step();
    chk("oor_clear_sel_err", 32'(sel_err), 0);
    chk("oor_clear_out", 32'(out), 0);
    chk("oor_clear_cur_ch", 32'(cur_ch), 0);
  endtask

  task automatic test_back_to_back();
    logic [2:0] sv [3] = '{3'd1, 3'd4, 3'd6};
    s_valid = 1'b1;
    s = sv[0];
    step();
    chk("b2b_first_edge_valid", 32'(out_valid), 0);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) s = sv[i+1];
      else s_valid = 1'b0;
      step();
      chk($sformatf("b2b_valid_%0d", i), 32'(out_valid), 1);
      chk($sformatf("b2b_cur_ch_%0d", i), 32'(cur_ch), 32'(sv[i]));
      chk($sformatf("b2b_out_%0d", i), 32'(out), 32'(a[sv[i]]));
    end
    step();
    chk("b2b_valid_drop", 32'(out_valid), 0);
  endtask

  task automatic test_scan();
    int exp_ch [16] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 0, 0};
    int wraps = 0;
    scan_en = 1'b1;
    step();
    chk("scan_entry_valid", 32'(out_valid), 0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("scan_ch_%0d", i), 32'(cur_ch), 32'(exp_ch[i]));
      chk($sformatf("scan_out_%0d", i), 32'(out), 32'(a[exp_ch[i]]));
      chk($sformatf("scan_valid_%0d", i), 32'(out_valid), 1);
      chk($sformatf("scan_wrap_%0d", i), 32'(wrap), (i == 14) ? 1 : 0);
      if (wrap === 1'b1) wraps++;
    end
    chk("scan_wrap_count", 32'(wraps), 1);
    scan_en = 1'b0;
    step();
    chk("scan_exit_valid", 32'(out_valid), 0);
    chk("scan_exit_hold_ch", 32'(cur_ch), 0);
    step();
  endtask

  task automatic test_reset_mid_scan();
    scan_en = 1'b1;
    step();
    for (int i = 0; i < 7; i++) step();
    chk("midscan_ch3", 32'(cur_ch), 3);
    rst = 1'b1;
    step();
    chk("midscan_rst_out", 32'(out), 0);
    chk("midscan_rst_valid", 32'(out_valid), 0);
    chk("midscan_rst_cur_ch", 32'(cur_ch), 0);
    chk("midscan_rst_wrap", 32'(wrap), 0);
    rst = 1'b0;
    step();
    chk("midscan_post_rst_valid", 32'(out_valid), 0);
    step();
    chk("midscan_restart_ch", 32'(cur_ch), 0);
    chk("midscan_restart_valid", 32'(out_valid), 1);
    step();
    chk("midscan_restart_ch_dwell", 32'(cur_ch), 0);
    step();
    chk("midscan_restart_ch1", 32'(cur_ch), 1);
    scan_en = 1'b0;
    step();
    step();
  endtask

  task automatic test_simultaneous();
    s = 3'd7; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    step();
    chk("simul_setup_sel_err", 32'(sel_err), 1);
    s = 3'd3; s_valid = 1'b1; scan_en = 1'b1;
    step();
    chk("simul_no_manual_valid", 32'(out_valid), 0);
    s = 3'd0;
    step();
    chk("simul_scan_ch", 32'(cur_ch), 0);
    chk("simul_scan_valid", 32'(out_valid), 1);
    chk("simul_sel_err_kept", 32'(sel_err), 1);
    step();
    chk("scan_ignores_s_valid_err", 32'(sel_err), 1);
    chk("scan_ignores_s_valid_ch", 32'(cur_ch), 0);
    s_valid = 1'b0; scan_en = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst = 1'b0; a = 7'b1010110; s = '0; s_valid = 1'b0; scan_en = 1'b0;
    test_reset();
    test_manual();
    test_out_of_range();
    test_back_to_back();
    test_scan();
    test_reset_mid_scan();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 Parameter N, default 7, number of input channels (2..64).
REQ-002 Parameter W, default 1, bits per channel (1..32).
REQ-003 Parameter DWELL, default 1, cycles each channel is held in scan mode (1..256).
REQ-004 Derived constant SW = max(1, clog2(N)), select width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 a  in  N*W  channel data; channel k occupies bits [k*W+W-1 : k*W].
REQ-008 s  in  SW  manual channel select.
REQ-009 s_valid  in  1  manual select request strobe.
REQ-010 scan_en  in  1  1 = auto-scan mode, 0 = manual mode.
REQ-011 out  out  W  registered selected channel data.
REQ-012 out_valid  out  1  out holds a fresh sample this cycle.
REQ-013 cur_ch  out  SW  channel index that produced out.
REQ-014 sel_err  out  1  last manual request used an out-of-range select.
REQ-015 wrap  out  1  one-cycle pulse when scan passes channel N-1 back to 0.

Function
REQ-016 FSM states IDLE, MANUAL, SCAN; state register updates on clk only.
REQ-017 IDLE: if scan_en=1, go to SCAN next cycle; else if s_valid=1, go to MANUAL; else stay.
REQ-018 MANUAL: single-cycle state; samples the request captured on entry, then returns to IDLE (or SCAN if scan_en=1).
REQ-019 Manual latency: s_valid high at edge T -> out=a[s], cur_ch=s, out_valid=1 after edge T+1; out_valid low next cycle unless another request.
REQ-020 Back-to-back s_valid on consecutive cycles each produce one out_valid cycle, one-for-one, no drops.
REQ-021 Out-of-range select (s >= N): out=0, cur_ch=s, out_valid=1, sel_err=1; never X.
REQ-022 sel_err holds until the next manual request, which clears or re-sets it.
REQ-023 SCAN: out_valid=1 every cycle; out=a[ch] sampled live each cycle for the current ch.
REQ-024 Scan channel counter starts at 0 on entry to SCAN; dwell counter advances ch after DWELL cycles.
REQ-025 Wrap: after DWELL cycles on channel N-1, ch returns to 0 and wrap=1 for exactly that first cycle on channel 0.
REQ-026 scan_en falling in SCAN: go to IDLE next edge; out/cur_ch hold last value, out_valid=0.
REQ-027 s_valid while in SCAN is ignored; sel_err unchanged.
REQ-028 s_valid and scan_en rising in the same IDLE cycle: scan_en wins; request discarded.
REQ-029 N not a power of two: scan never visits indices >= N.

Reset
REQ-030 rst=1 at an edge: state=IDLE, out=0, out_valid=0, cur_ch=0, sel_err=0, wrap=0, counters=0.
REQ-031 rst mid-scan or mid-request overrides all inputs that cycle; no output pulse follows reset.
REQ-032 First action possible on the edge after rst deasserts.

Structure
REQ-033 Shared package holds the state enum (IDLE, MANUAL, SCAN) and a clog2-based select-width function.
REQ-034 One sub-module, scan_mux_sel: combinational N:1 W-bit selector with range check, used by both modes.
REQ-035 No latches; all outputs driven from registers.

Verification
REQ-036 N=7,W=1,a=7'b1010110; s=2,s_valid pulse -> one cycle later out=1, cur_ch=2, out_valid=1, sel_err=0.
REQ-037 N=7, s=7 (3'b111), s_valid -> out=0, sel_err=1, out_valid=1; next request s=0 clears sel_err.
REQ-038 N=7,DWELL=2, scan_en=1 for 16 cycles -> cur_ch sequence 0,0,1,1,...,6,6,0,0; wrap high once on return to 0.
REQ-039 s_valid on 3 consecutive cycles with s=1,4,6 -> three consecutive out_valid cycles with cur_ch 1,4,6.
REQ-040 rst asserted while cur_ch=3 in SCAN -> next cycle all outputs 0, state IDLE; scan restarts at channel 0.
REQ-041 scan_en and s_valid rise together -> SCAN entered, no manual out_valid, sel_err unchanged.
